rx_host_sched: RTL and testbench
================================

Name: rx_host_sched

Overview:
- Command scheduler in front of rx_host. Shares its single write/read command path between NREQ requesters using round-robin arbitration.
- rx_host latches at most one command per 512-cycle frame, so this block enforces one command in flight per frame and routes each read response back to its issuer.
- Also forwards sample-delay configuration (rx_host addr 1) with priority over requesters.

Parameters:
NREQ, 4, number of requesters (2..8)
SLOT_CYCLES, 512, post-issue hold-off for write commands; must be >= rx_host frame length
TIMEOUT, 1024, maximum cycles to wait for host_rvalid after issuing a read

Ports:
clock  input  1  125 MHz system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  requester i has a command pending; held until req_ready[i]
req_data  input  21*NREQ  command of requester i at [21*i+20:21*i]; bit 20 read, 19:16 addr, 15:0 data
req_ready  output  NREQ  one-cycle, one-hot acceptance pulse
resp_valid  output  NREQ  one-cycle, one-hot read-response pulse to the issuing requester
resp_data  output  16  read data, valid with resp_valid
resp_err  output  1  read timed out, valid with resp_valid
delay_valid  input  1  sample-delay write request
delay_value  input  3  sample-delay value
delay_ready  output  1  one-cycle acceptance pulse for delay write
host_wvalid  output  1  to rx_host wvalid
host_wdata  output  21  to rx_host wdata
host_addr  output  2  to rx_host addr (0 = command, 1 = delay)
host_rdata  input  64  from rx_host rdata; only [15:0] used
host_rvalid  input  1  from rx_host rvalid
busy  output  1  high when not in IDLE

Behaviour:
- Clock and reset: one clock (clock). reset_n is asynchronous and active-low.
- Reset values: all outputs 0. State IDLE. Counters 0. RR pointer = NREQ-1, so requester 0 has first priority.
- Reset mid-operation: the in-flight command is abandoned and no resp_valid is produced.
- All outputs are registered.

States:
- IDLE:
  - If delay_valid: next cycle drive host_wvalid=1, host_addr=1, host_wdata={18'b0,delay_value}, delay_ready=1. Stay IDLE. No hold-off, because delay applies immediately in rx_host.
  - Else if any req_valid: grant the first set bit searching from pointer+1, wrapping modulo NREQ. Set pointer to the granted index. Next cycle drive host_wvalid=1, host_addr=0, host_wdata=req_data slice, req_ready[g]=1. Go to WAIT_SLOT (bit 20 = 0) or WAIT_READ (bit 20 = 1). Load counter to 0.
  - Delay wins over simultaneous requests. A requester whose req_valid is still high is re-granted only after the state returns to IDLE.
- WAIT_SLOT: count up; when count == SLOT_CYCLES-1, go to IDLE. Requests and delay writes are stalled here.
- WAIT_READ:
  - On host_rvalid: next cycle resp_valid[g]=1, resp_data=host_rdata[15:0], resp_err=0; go to IDLE.
  - When count == TIMEOUT-1 without rvalid: resp_valid[g]=1, resp_data=16'hFFFF, resp_err=1; go to IDLE.
  - If rvalid and timeout occur in the same cycle, rvalid wins.
- host_rvalid outside WAIT_READ (stale or late) is ignored and produces no resp_valid.
- host_wvalid, req_ready, delay_ready and resp_valid are single-cycle pulses. host_wdata and host_addr hold their last value otherwise.
- Latency:
  - req_valid sampled in IDLE -> host_wvalid one cycle later.
  - host_rvalid -> resp_valid one cycle later.
- Throughput: the minimum spacing between consecutive command issues is SLOT_CYCLES+1 cycles for writes.

Test Plan:
- Single write: req_valid[2]=1, req_data[2]=21'h0_3_1234 from reset -> one cycle later host_wvalid=1, host_addr=0, host_wdata=21'h031234, req_ready=4'b0100; next host_wvalid no earlier than 513 cycles after it; busy high throughout.
- Round-robin: all four req_valid held high -> grants in order 0,1,2,3,0, each spaced SLOT_CYCLES+1 cycles; no requester is granted twice before all others have been granted.
- Read: req_valid[1] with bit20=1, addr 5 -> host_wdata=21'h150000; bench pulses host_rvalid with host_rdata[15:0]=16'hBEEF 300 cycles later -> next cycle resp_valid=4'b0010, resp_data=16'hBEEF, resp_err=0; state returns to IDLE.
- Timeout: read issued with no host_rvalid -> resp_valid one-hot to issuer exactly 1024 cycles after host_wvalid, resp_data=16'hFFFF, resp_err=1; a host_rvalid 10 cycles later produces no response.
- Priority and delay: delay_valid=1, delay_value=3'd5 together with req_valid[0] in IDLE -> first host_wvalid has host_addr=1, host_wdata=21'h5, delay_ready=1; request 0 issues on the following cycle.
- Reset mid-read: assert reset_n=0 during WAIT_READ -> all outputs 0 immediately (asynchronous); after release, requester 0 has priority and a subsequent host_rvalid causes no resp_valid.

Source files
------------

// File: rtl/rx_host_sched.sv
// rx_host_sched: command scheduler in front of rx_host.
// Arbitrates the single rx_host command path among NREQ requesters using
// round-robin arbitration. Only one command is in flight at a time, and each
// read response is routed back to the requester that issued the read.
// Sample-delay writes bypass arbitration and take priority over requesters.
module rx_host_sched #(
    parameter int NREQ        = 4,
    parameter int SLOT_CYCLES = 512,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [21*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [15:0]          resp_data,
    output logic                 resp_err,
    input  logic                 delay_valid,
    input  logic [2:0]           delay_value,
    output logic                 delay_ready,
    output logic                 host_wvalid,
    output logic [20:0]          host_wdata,
    output logic [1:0]           host_addr,
    input  logic [63:0]          host_rdata,
    input  logic                 host_rvalid,
    output logic                 busy
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAXC = (SLOT_CYCLES > TIMEOUT) ? SLOT_CYCLES : TIMEOUT;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_WAIT_READ = 2'd2
    } state_t;

    // Round-robin pick: first set bit of vld searching upward from ptr+1,
    // wrapping modulo NREQ. Returns {found, index}.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] vld,
                                            input logic [PW-1:0]   ptr);
        logic          found;
        logic [PW-1:0] idx;
        int            cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && vld[cand[PW-1:0]]) begin
                found = 1'b1;
                idx   = cand[PW-1:0];
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // FSM and datapath state
    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr;
    logic [PW-1:0]   r_grant;
    logic [PW-1:0]   w_grant;

    // Registered outputs and their next values
    logic [NREQ-1:0] r_req_ready;
    logic [NREQ-1:0] w_req_ready;
    logic [NREQ-1:0] r_resp_valid;
    logic [NREQ-1:0] w_resp_valid;
    logic [15:0]     r_resp_data;
    logic [15:0]     w_resp_data;
    logic            r_resp_err;
    logic            w_resp_err;
    logic            r_delay_ready;
    logic            w_delay_ready;
    logic            r_host_wvalid;
    logic            w_host_wvalid;
    logic [20:0]     r_host_wdata;
    logic [20:0]     w_host_wdata;
    logic [1:0]      r_host_addr;
    logic [1:0]      w_host_addr;
    logic            r_busy;

    // Arbitration results
    logic [PW:0]     w_pick;
    logic            w_pick_found;
    logic [PW-1:0]   w_pick_idx;
    logic [20:0]     w_pick_cmd;
    logic [20:0]     w_req_cmd [NREQ];

    // Only the low 16 bits of the host read bus carry data.
    logic            w_unused_rdata;
    assign w_unused_rdata = ^host_rdata[63:16];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cmd
        assign w_req_cmd[gi] = req_data[21*gi +: 21];
    end

    assign w_pick       = rr_pick(req_valid, r_ptr);
    assign w_pick_found = w_pick[PW];
    assign w_pick_idx   = w_pick[PW-1:0];
    assign w_pick_cmd   = w_req_cmd[w_pick_idx];

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: delay writes keep the FSM idle, commands start a wait
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (delay_valid) begin
                    w_next_state = ST_IDLE;
                end else if (w_pick_found) begin
                    w_next_state = w_pick_cmd[20] ? ST_WAIT_READ : ST_WAIT_SLOT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT_SLOT: begin
                if (r_cnt == SLOT_LAST) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT_SLOT;
                end
            end
            ST_WAIT_READ: begin
                if (host_rvalid || (r_cnt == TO_LAST)) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT_READ;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values: pulses default low, buses hold
    always_comb begin
        w_req_ready   = '0;
        w_resp_valid  = '0;
        w_resp_data   = r_resp_data;
        w_resp_err    = r_resp_err;
        w_delay_ready = 1'b0;
        w_host_wvalid = 1'b0;
        w_host_wdata  = r_host_wdata;
        w_host_addr   = r_host_addr;
        w_cnt         = r_cnt;
        w_ptr         = r_ptr;
        w_grant       = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (delay_valid) begin
                    // Delay applies immediately in rx_host, so no hold-off.
                    w_host_wvalid = 1'b1;
                    w_host_addr   = 2'd1;
                    w_host_wdata  = {18'b0, delay_value};
                    w_delay_ready = 1'b1;
                end else if (w_pick_found) begin
                    w_host_wvalid          = 1'b1;
                    w_host_addr            = 2'd0;
                    w_host_wdata           = w_pick_cmd;
                    w_req_ready[w_pick_idx] = 1'b1;
                    w_ptr                  = w_pick_idx;
                    w_grant                = w_pick_idx;
                    w_cnt                  = '0;
                end else begin
                    w_cnt = '0;
                end
            end
            ST_WAIT_SLOT: begin
                if (r_cnt == SLOT_LAST) begin
                    w_cnt = '0;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            ST_WAIT_READ: begin
                if (host_rvalid) begin
                    // A response arriving on the timeout cycle still wins.
                    w_resp_valid[r_grant] = 1'b1;
                    w_resp_data           = host_rdata[15:0];
                    w_resp_err            = 1'b0;
                    w_cnt                 = '0;
                end else if (r_cnt == TO_LAST) begin
                    w_resp_valid[r_grant] = 1'b1;
                    w_resp_data           = 16'hFFFF;
                    w_resp_err            = 1'b1;
                    w_cnt                 = '0;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_cnt = '0;
            end
        endcase
    end

    // Datapath registers: wait counter, round-robin pointer, issuing requester
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_ptr   <= PW'(NREQ - 1);
            r_grant <= '0;
        end else begin
            r_cnt   <= w_cnt;
            r_ptr   <= w_ptr;
            r_grant <= w_grant;
        end
    end

    // Output registers; busy tracks the state the FSM is entering
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_req_ready   <= '0;
            r_resp_valid  <= '0;
            r_resp_data   <= '0;
            r_resp_err    <= 1'b0;
            r_delay_ready <= 1'b0;
            r_host_wvalid <= 1'b0;
            r_host_wdata  <= '0;
            r_host_addr   <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_req_ready   <= w_req_ready;
            r_resp_valid  <= w_resp_valid;
            r_resp_data   <= w_resp_data;
            r_resp_err    <= w_resp_err;
            r_delay_ready <= w_delay_ready;
            r_host_wvalid <= w_host_wvalid;
            r_host_wdata  <= w_host_wdata;
            r_host_addr   <= w_host_addr;
            r_busy        <= (w_next_state != ST_IDLE);
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign resp_err    = r_resp_err;
    assign delay_ready = r_delay_ready;
    assign host_wvalid = r_host_wvalid;
    assign host_wdata  = r_host_wdata;
    assign host_addr   = r_host_addr;
    assign busy        = r_busy;

endmodule

// File: tb/tb_rx_host_sched.sv
// Directed self-checking bench for rx_host_sched (NREQ=4, SLOT_CYCLES=512,
// TIMEOUT=1024). Inputs change 1 ns after the rising edge; outputs are
// checked at that same point, away from the active edge.
module tb_rx_host_sched;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [83:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        delay_valid;
    logic [2:0]  delay_value;
    logic        delay_ready;
    logic        host_wvalid;
    logic [20:0] host_wdata;
    logic [1:0]  host_addr;
    logic [63:0] host_rdata;
    logic        host_rvalid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    rx_host_sched #(.NREQ(4), .SLOT_CYCLES(512), .TIMEOUT(1024)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .delay_valid (delay_valid),
        .delay_value (delay_value),
        .delay_ready (delay_ready),
        .host_wvalid (host_wvalid),
        .host_wdata  (host_wdata),
        .host_addr   (host_addr),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .busy        (busy)
    );

    // 125 MHz clock
    initial begin
        clock = 1'b0;
        forever #4 clock = ~clock;
    end

    // Hang guard
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sel: 0 host_wvalid, 1 any resp_valid, 2 busy low, 3 delay_ready
    function automatic logic sig_now(input int sel);
        case (sel)
            0:       return host_wvalid;
            1:       return (resp_valid != 4'b0000);
            2:       return !busy;
            3:       return delay_ready;
            default: return 1'b0;
        endcase
    endfunction

    // Ticks until the selected event is seen or the budget runs out.
    task automatic wait_sig(input int sel, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sig_now(sel) && n < budget);
    endtask

    initial begin
        int          n;
        int          busy_cnt;
        int          seen;
        int          exp_g;
        logic [3:0]  oh;
        logic [20:0] cmd;

        reset_n     = 1'b0;
        req_valid   = 4'b0000;
        req_data    = 84'd0;
        delay_valid = 1'b0;
        delay_value = 3'd0;
        host_rdata  = 64'd0;
        host_rvalid = 1'b0;

        // ---- reset state ----
        #20;
        chk("rst_wvalid", host_wvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_outs", {req_ready, resp_valid, resp_data, resp_err, delay_ready, host_wdata, host_addr},
            64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // ---- single write from requester 2 ----
        req_valid = 4'b0100;
        req_data[42 +: 21] = 21'h031234;
        tick();
        chk("wr_wvalid", host_wvalid, 1'b1);
        chk("wr_addr", host_addr, 2'd0);
        chk("wr_wdata", host_wdata, 21'h031234);
        chk("wr_ready", req_ready, 4'b0100);
        chk("wr_busy", busy, 1'b1);
        // Requester keeps a second command pending; it must wait out the slot.
        busy_cnt = 0;
        n = 0;
        do begin
            tick();
            n++;
            if (n <= 512 && busy) busy_cnt++;
        end while (!host_wvalid && n < 700);
        chk("wr_spacing", n, 513);
        chk("wr_busy_cycles", busy_cnt, 511);
        chk("wr_ready2", req_ready, 4'b0100);
        req_valid = 4'b0000;
        wait_sig(2, 600, n);
        chk("wr_idle", n, 512);

        // ---- round robin after a fresh reset ----
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_data[21*i +: 21] = {1'b0, 4'(i + 8), 16'hA000 + 16'(i)};
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_sig(0, 600, n);
            exp_g = k % 4;
            oh  = 4'b0001 << exp_g;
            cmd = {1'b0, 4'(exp_g + 8), 16'hA000 + 16'(exp_g)};
            chk("rr_spacing", n, (k == 0) ? 1 : 513);
            chk("rr_ready", req_ready, oh);
            chk("rr_wdata", host_wdata, cmd);
        end
        req_valid = 4'b0000;
        wait_sig(2, 600, n);

        // ---- read from requester 1 answered after 300 cycles ----
        req_valid = 4'b0010;
        req_data[21 +: 21] = 21'h150000;
        tick();
        chk("rd_wvalid", host_wvalid, 1'b1);
        chk("rd_wdata", host_wdata, 21'h150000);
        chk("rd_ready", req_ready, 4'b0010);
        req_valid = 4'b0000;
        seen = 0;
        repeat (299) begin
            tick();
            if (resp_valid != 4'b0000) seen++;
        end
        host_rvalid = 1'b1;
        host_rdata  = 64'h0123_4567_89AB_BEEF;
        tick();
        host_rvalid = 1'b0;
        chk("rd_early_resp", seen, 0);
        chk("rd_resp_valid", resp_valid, 4'b0010);
        chk("rd_resp_data", resp_data, 16'hBEEF);
        chk("rd_resp_err", resp_err, 1'b0);
        chk("rd_idle", busy, 1'b0);
        tick();
        chk("rd_resp_pulse", resp_valid, 4'b0000);

        // ---- read from requester 3 that times out ----
        req_valid = 4'b1000;
        req_data[63 +: 21] = 21'h120000;
        tick();
        chk("to_ready", req_ready, 4'b1000);
        chk("to_wdata", host_wdata, 21'h120000);
        req_valid = 4'b0000;
        wait_sig(1, 1200, n);
        chk("to_latency", n, 1024);
        chk("to_resp_valid", resp_valid, 4'b1000);
        chk("to_resp_data", resp_data, 16'hFFFF);
        chk("to_resp_err", resp_err, 1'b1);
        repeat (9) tick();
        host_rvalid = 1'b1;
        host_rdata  = 64'h0000_0000_0000_1111;
        tick();
        host_rvalid = 1'b0;
        seen = 0;
        repeat (4) begin
            if (resp_valid != 4'b0000) seen++;
            tick();
        end
        chk("to_late_rvalid", seen, 0);

        // ---- delay write beats a simultaneous request ----
        delay_valid = 1'b1;
        delay_value = 3'd5;
        req_valid   = 4'b0001;
        req_data[0 +: 21] = 21'h0700AA;
        tick();
        delay_valid = 1'b0;
        chk("dly_wvalid", host_wvalid, 1'b1);
        chk("dly_addr", host_addr, 2'd1);
        chk("dly_wdata", host_wdata, 21'h000005);
        chk("dly_ready", delay_ready, 1'b1);
        chk("dly_no_req_ready", req_ready, 4'b0000);
        tick();
        chk("dly_req_wvalid", host_wvalid, 1'b1);
        chk("dly_req_addr", host_addr, 2'd0);
        chk("dly_req_wdata", host_wdata, 21'h0700AA);
        chk("dly_req_ready", req_ready, 4'b0001);
        chk("dly_ready_pulse", delay_ready, 1'b0);
        req_valid = 4'b0000;
        // A delay write arriving during the slot is stalled until IDLE.
        delay_valid = 1'b1;
        delay_value = 3'd2;
        wait_sig(3, 700, n);
        delay_valid = 1'b0;
        chk("dly_stall", n, 513);
        chk("dly_stall_addr", host_addr, 2'd1);
        chk("dly_stall_wdata", host_wdata, 21'h000002);

        // ---- reset in the middle of a read ----
        tick();
        req_valid = 4'b0100;
        req_data[42 +: 21] = 21'h1A0000;
        tick();
        chk("mr_ready", req_ready, 4'b0100);
        req_valid = 4'b0000;
        repeat (20) tick();
        chk("mr_busy_before", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_busy_async", busy, 1'b0);
        chk("mr_wdata_async", host_wdata, 21'h000000);
        chk("mr_resp_async", resp_valid, 4'b0000);
        @(posedge clock);
        #1 reset_n = 1'b1;
        host_rvalid = 1'b1;
        host_rdata  = 64'h0000_0000_0000_BEEF;
        tick();
        host_rvalid = 1'b0;
        seen = 0;
        repeat (4) begin
            if (resp_valid != 4'b0000) seen++;
            tick();
        end
        chk("mr_no_resp", seen, 0);
        req_data[0 +: 21]  = 21'h000011;
        req_data[63 +: 21] = 21'h0F0033;
        req_valid = 4'b1001;
        tick();
        req_valid = 4'b0000;
        chk("mr_prio_ready", req_ready, 4'b0001);
        chk("mr_prio_wdata", host_wdata, 21'h000011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
